mips_bus_fabric: RTL

Parametrised memory-mapped interconnect between the MIPS core data port and NUM_SLAVES peripherals (memory, UART, timers, GPIO). It decodes the top address bits into a one-hot slave select and runs a request/ready handshake so that slow slaves can insert wait states. Unanswered accesses are terminated by a timeout with a bus error. It replaces the fixed, single-cycle, two-way decode of the current top level.

---
 rtl/mips_bus_fabric.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mips_bus_fabric.sv
// Memory-mapped interconnect: one-hot slave decode, ready handshake with timeout/bus error.
// Optional BUS_FABRIC_ERR_ADDR_EN keeps the address of the last faulting access on err_addr.
module mips_bus_fabric #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   m_req,
    input  logic [ADDR_WIDTH-1:0]                  m_addr,
    input  logic                                   m_wr_en,
    input  logic [DATA_WIDTH-1:0]                  m_wr_data,
    output logic [DATA_WIDTH-1:0]                  m_rd_data,
    output logic                                   m_ready,
    output logic                                   m_err,
    output logic [NUM_SLAVES-1:0]                  s_sel,
    output logic [ADDR_WIDTH-$clog2(NUM_SLAVES)-1:0] s_addr,
    output logic [DATA_WIDTH-1:0]                  s_wr_data,
    output logic                                   s_wen,
    output logic                                   s_ren,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]       s_rd_data,
    input  logic [NUM_SLAVES-1:0]                  s_ready,
    output logic [ERR_CNT_WIDTH-1:0]               err_cnt,
    output logic [ADDR_WIDTH-1:0]                  err_addr
);

    localparam int SEL_WIDTH = $clog2(NUM_SLAVES);
    localparam int LOC_WIDTH = ADDR_WIDTH - SEL_WIDTH;
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [SEL_WIDTH-1:0]   idx;
    logic [SEL_WIDTH-1:0]   m_idx;
    logic [LOC_WIDTH-1:0]   loc;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   err;
    logic                   dec_err;
    logic                   sel_ready;
    logic                   timeout;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [NUM_SLAVES-1:0]  sel_oh;

    assign m_idx   = m_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
    assign dec_err = {1'b0, m_idx} >= (SEL_WIDTH + 1)'(NUM_SLAVES);

    // idx is only in range while in ACCESS; outside it the decode is masked off
    always_comb begin
        sel_oh   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_WIDTH'(i)) begin
                sel_oh[i] = 1'b1;
                sel_data  = s_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_ready = |(s_ready & sel_oh);
    assign timeout   = cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m_req) begin
                    state_nx = dec_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (sel_ready || timeout) begin
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_sel     = '0;
        s_addr    = '0;
        s_wr_data = '0;
        s_wen     = 1'b0;
        s_ren     = 1'b0;
        m_ready   = 1'b0;
        m_rd_data = '0;
        m_err     = 1'b0;
        if (state == ACCESS) begin
            s_sel     = sel_oh;
            s_addr    = loc;
            s_wr_data = wr_data;
            s_wen     = wr_en;
            s_ren     = ~wr_en;
        end
        if (state == RESP) begin
            m_ready   = 1'b1;
            m_rd_data = rd_data;
            m_err     = err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            loc     <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
            rd_data <= '0;
            err     <= 1'b0;
            cnt     <= '0;
            err_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req) begin
                        idx     <= m_idx;
                        loc     <= m_addr[LOC_WIDTH-1:0];
                        wr_en   <= m_wr_en;
                        wr_data <= m_wr_data;
                        rd_data <= '0;
                        err     <= dec_err;
                        cnt     <= '0;
                    end
                end
                ACCESS: begin
                    // a ready in the timeout cycle still completes cleanly
                    if (sel_ready) begin
                        err <= 1'b0;
                        if (!wr_en) begin
                            rd_data <= sel_data;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout) begin
                            err     <= 1'b1;
                            rd_data <= '0;
                        end
                    end
                end
                RESP: begin
                    if (err && err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BUS_FABRIC_ERR_ADDR_EN
    logic [ADDR_WIDTH-1:0] err_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_addr_q <= '0;
        end else if (state == RESP && err) begin
            err_addr_q <= {idx, loc};
        end
    end

    assign err_addr = err_addr_q;
`else
    assign err_addr = '0;
`endif

endmodule
